wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
- 4-master to 1-slave Wishbone classic arbiter.
- Lets the LM32 data port and up to three hardware masters (IMU poller, DMA, debug) share one slave, e.g. the I2C or PWM peripheral.
- Round-robin grant that is held for a whole bus cycle (cyc high).
- Per-transfer ack watchdog that terminates hung transfers with err.

Parameters:
- TIMEOUT, 256: max cycles stb may wait for s_ack_i before abort; 0 disables the watchdog; valid range 0..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_adr_i  in  128  master addresses, master k at [32k+31:32k]
- m_dat_i  in  128  master write data, same packing
- m_sel_i  in  16  byte selects, master k at [4k+3:4k]
- m_we_i  in  4  write enable per master
- m_cyc_i  in  4  cycle request per master
- m_stb_i  in  4  strobe per master
- m_dat_o  out  32  read data, broadcast to all masters (= s_dat_i)
- m_ack_o  out  4  ack, only the owner's bit can be set
- m_err_o  out  4  timeout error, one-cycle pulse to the owner
- s_adr_o  out  32  slave address
- s_dat_o  out  32  slave write data
- s_sel_o  out  4  slave byte selects
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_dat_i  in  32  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  index of the current owner (valid when busy_o=1)
- busy_o  out  1  1 while in GRANT or ERR

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr pointer=0; timeout counter=0; grant_o=0.
  - All outputs 0.
  - A reset asserted mid-transfer drops s_cyc_o/s_stb_o on the next edge; no ack or err is produced for that transfer.
- State IDLE:
  - Requests = m_cyc_i.
  - If any request is set, pick the first set bit searching from ptr upward with wrap (ptr, ptr+1, … mod 4).
  - Register the winner in grant_o and go to GRANT.
  - Arbitration latency: exactly 1 cycle from m_cyc_i rising to s_cyc_o rising.
- State GRANT:
  - s_adr_o/s_dat_o/s_sel_o/s_we_o/s_stb_o/s_cyc_o are combinational muxes of the owner's inputs.
  - s_cyc_o = m_cyc_i[owner]; s_stb_o = m_stb_i[owner] & m_cyc_i[owner].
  - m_ack_o[owner] = s_ack_i (combinational); all other ack bits are 0.
  - Grant is held while m_cyc_i[owner]=1, so block/RMW sequences are never interleaved.
  - When m_cyc_i[owner]=0: go to IDLE, set ptr = owner+1 (mod 4).
  - One mandatory idle cycle between owners.
- State ERR:
  - Slave outputs forced to 0.
  - m_err_o[owner]=1 for the first ERR cycle only.
  - Stay in ERR until m_cyc_i[owner]=0, then go to IDLE with ptr = owner+1.
- Outside GRANT, all slave-side outputs and m_ack_o are 0; mux outputs are 0 when not in GRANT.
- Watchdog (TIMEOUT>0):
  - 16-bit counter, cleared on entry to GRANT, on any s_ack_i, and whenever s_stb_o=0.
  - Increments each GRANT cycle with s_stb_o=1 and s_ack_i=0.
  - When it reaches TIMEOUT-1 with no ack: GRANT→ERR.
  - If s_ack_i arrives in the same cycle the counter reaches TIMEOUT-1, the ack wins and the counter clears.
- Simultaneous requests: resolved purely by the rr pointer. No starvation: each waiting master is served within 3 other ownerships.
- A master that raises cyc while another owns the bus waits with ack=0; its stb is ignored.
- An owner dropping cyc in the same cycle as s_ack_i: the ack is still routed to it in that cycle.

Optional Feature:
- Macro: WB_ARB_FIXED_PRIORITY_EN.
- Defined: IDLE grants the lowest-index requesting master (master 0 highest priority). The rr pointer is removed or ignored; the hold-for-cyc, timeout and idle-gap rules are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: m_cyc_i=0001 with write to 0x50000004, slave acks after 2 cycles → s_cyc_o rises 1 cycle after m_cyc_i; s_adr_o=0x50000004; m_ack_o=0001 for one cycle; then grant released.
- Contention: all four masters hold cyc from reset, each does one 1-ack transfer then drops cyc → grant order 0,1,2,3,0 with one idle cycle between owners.
- Block hold: master 2 keeps cyc high for 3 stb/ack beats while master 1 requests → master 1 sees no ack until master 2 drops cyc; next grant goes to master 3 if it is requesting, else master 1.
- Timeout: TIMEOUT=16, slave never acks → m_err_o[owner] pulses exactly 16 cycles after stb is presented; s_cyc_o=0 from then on; next master granted after the owner drops cyc.
- Ack/timeout race: ack arrives exactly on cycle TIMEOUT-1 → m_ack_o asserted, no m_err_o.
- Mid-transfer reset: assert reset during a GRANT stb with no ack → next cycle all outputs 0, grant_o=0; after release, master 0 is granted first when all masters request.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Brief    : 4-master to 1-slave Wishbone classic arbiter, round-robin grant
//            held for a whole bus cycle, with a per-transfer ack watchdog.
//            Define WB_ARB_FIXED_PRIORITY_EN for fixed priority (master 0 first).
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] m_adr_i,
    input  logic [127:0] m_dat_i,
    input  logic [15:0]  m_sel_i,
    input  logic [3:0]   m_we_i,
    input  logic [3:0]   m_cyc_i,
    input  logic [3:0]   m_stb_i,
    output logic [31:0]  m_dat_o,
    output logic [3:0]   m_ack_o,
    output logic [3:0]   m_err_o,
    output logic [31:0]  s_adr_o,
    output logic [31:0]  s_dat_o,
    output logic [3:0]   s_sel_o,
    output logic         s_we_o,
    output logic         s_cyc_o,
    output logic         s_stb_o,
    input  logic [31:0]  s_dat_i,
    input  logic         s_ack_i,
    output logic [1:0]   grant_o,
    output logic         busy_o
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic        c_wdog_en   = (TIMEOUT != 0);
    localparam logic [15:0] c_wdog_last = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_winner;
    logic [15:0] r_wdog;
    logic        r_err_first;
    logic        w_any_req;
    logic        w_own_cyc;
    logic        w_own_stb;
    logic        w_timeout;
    logic        w_release;

    assign w_any_req = |m_cyc_i;
    assign w_own_cyc = m_cyc_i[r_grant];
    assign w_own_stb = m_stb_i[r_grant] & w_own_cyc;
    assign w_release = (r_state != ST_IDLE) && !w_own_cyc;
    // A same-cycle ack beats the watchdog on its last count.
    assign w_timeout = c_wdog_en && (r_state == ST_GRANT) && w_own_stb && !s_ack_i
                       && (r_wdog == c_wdog_last);

`ifdef WB_ARB_FIXED_PRIORITY_EN
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m_cyc_i[i]) w_winner = 2'(i);
        end
    end
`else
    logic [1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (reset)          r_ptr <= 2'd0;
        else if (w_release) r_ptr <= r_grant + 2'd1;
    end

    // Scanning offsets downward leaves the nearest requester at or after r_ptr.
    always_comb begin
        w_winner = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (m_cyc_i[r_ptr + 2'(i)]) w_winner = r_ptr + 2'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req)  w_state_nxt = ST_GRANT;
            ST_GRANT: if (!w_own_cyc) w_state_nxt = ST_IDLE;
                      else if (w_timeout) w_state_nxt = ST_ERR;
            ST_ERR:   if (!w_own_cyc) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= 2'd0;
            r_wdog      <= 16'd0;
            r_err_first <= 1'b0;
        end else begin
            r_err_first <= (r_state == ST_GRANT) && w_own_cyc && w_timeout;
            if ((r_state == ST_IDLE) && w_any_req) r_grant <= w_winner;
            if ((r_state != ST_GRANT) || !w_own_stb || s_ack_i) r_wdog <= 16'd0;
            else if (!w_timeout)                                r_wdog <= r_wdog + 16'd1;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (r_state == ST_GRANT) begin
            s_adr_o          = m_adr_i[{r_grant, 5'd0} +: 32];
            s_dat_o          = m_dat_i[{r_grant, 5'd0} +: 32];
            s_sel_o          = m_sel_i[{r_grant, 2'd0} +: 4];
            s_we_o           = m_we_i[r_grant];
            s_cyc_o          = w_own_cyc;
            s_stb_o          = w_own_stb;
            m_dat_o          = s_dat_i;
            m_ack_o[r_grant] = s_ack_i;
        end
        if (r_state == ST_ERR) m_err_o[r_grant] = r_err_first;
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
